// File: rtl/rvfi_mon_pkg.sv
// Shared types and the compressed-aware instruction compare for the RVFI progress monitor.
`timescale 1ns/1ps
package rvfi_mon_pkg;

  localparam int unsigned ILEN_DEFAULT = 32;
  // Widest instruction the shared compare function accepts; narrower ILEN is zero-extended.
  localparam int unsigned ILEN_MAX = 64;

  // One-hot encoding so the state view outputs are plain register bits.
  typedef enum logic [2:0] {
    ARMED   = 3'b001,
    MATCHED = 3'b010,
    TIMEOUT = 3'b100
  } mon_state_e;

  // A 16-bit (compressed) target only constrains the low halfword of the retired insn.
  function automatic logic insn_hit(input logic [ILEN_MAX-1:0] match,
                                    input logic [ILEN_MAX-1:0] insn);
    if (match[1:0] == 2'b11) begin
      return match == insn;
    end
    return match[15:0] == insn[15:0];
  endfunction

endpackage

// File: rtl/rvfi_insn_matcher.sv
// Combinational per-channel hit detector: retire strobe qualified by the target compare.
`timescale 1ns/1ps
module rvfi_insn_matcher
  import rvfi_mon_pkg::*;
#(
  parameter int unsigned ILEN = ILEN_DEFAULT
) (
  input  logic            valid,
  input  logic [ILEN-1:0] match_insn,
  input  logic [ILEN-1:0] insn,
  output logic            hit
);

  assign hit = valid && insn_hit(ILEN_MAX'(match_insn), ILEN_MAX'(insn));

endmodule

// File: rtl/rvfi_progress_monitor.sv
// Liveness monitor: flags whether a target instruction retires within MAX_CYCLES of arming,
// counts retirements and checks the memory handshake for over-long wait runs.
`timescale 1ns/1ps
module rvfi_progress_monitor
  import rvfi_mon_pkg::*;
#(
  parameter int unsigned NRET       = 1,
  parameter int unsigned ILEN       = ILEN_DEFAULT,
  parameter int unsigned MAX_CYCLES = 21,
  parameter int unsigned MAX_WAIT   = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     clear,
  input  logic [ILEN-1:0]                          match_insn,
  input  logic [NRET-1:0]                          rvfi_valid,
  input  logic [NRET*ILEN-1:0]                     rvfi_insn,
  input  logic                                     mem_valid,
  input  logic                                     mem_ready,
  output logic                                     armed,
  output logic                                     matched,
  output logic                                     timeout,
  output logic                                     stall_err,
  output logic [((NRET > 1) ? $clog2(NRET) : 1)-1:0] match_slot,
  output logic [CNT_W-1:0]                         cycle_count,
  output logic [CNT_W-1:0]                         retire_count
);

  localparam int unsigned SLOT_W = (NRET > 1) ? $clog2(NRET) : 1;
  localparam int unsigned POP_W  = $clog2(NRET + 1);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  mon_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  retire_q, retire_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;

  logic [NRET-1:0]   hit;
  logic [SLOT_W-1:0] slot_enc;
  logic [POP_W-1:0]  pop;
  logic [CNT_W:0]    retire_sum;
  logic              stall;

  for (genvar k = 0; k < NRET; k++) begin : g_match
    rvfi_insn_matcher #(
      .ILEN(ILEN)
    ) u_matcher (
      .valid     (rvfi_valid[k]),
      .match_insn(match_insn),
      .insn      (rvfi_insn[k*ILEN +: ILEN]),
      .hit       (hit[k])
    );
  end

  // Lowest hitting channel wins, so scan from the top down.
  always_comb begin
    slot_enc = '0;
    for (int k = int'(NRET) - 1; k >= 0; k--) begin
      if (hit[k]) slot_enc = SLOT_W'(k);
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned k = 0; k < NRET; k++) begin
      pop = pop + POP_W'(rvfi_valid[k]);
    end
  end

  assign retire_sum = {1'b0, retire_q} + (CNT_W + 1)'(pop);
  assign stall      = mem_valid && !mem_ready;

  always_comb begin
    state_d  = state_q;
    cycle_d  = cycle_q;
    slot_d   = slot_q;
    retire_d = retire_sum[CNT_W] ? '1 : retire_sum[CNT_W-1:0];
    wait_d   = '0;
    err_d    = err_q;

    if (stall) begin
      if (wait_q == WAIT_W'(MAX_WAIT)) begin
        err_d  = 1'b1;
        wait_d = wait_q;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end

    unique case (state_q)
      ARMED: begin
        if (|hit) begin
          state_d = MATCHED;
          slot_d  = slot_enc;
        end else if (cycle_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d = TIMEOUT;
        end else begin
          cycle_d = cycle_q + CNT_W'(1);
        end
      end
      default: ;
    endcase

    if (clear) begin
      state_d  = ARMED;
      cycle_d  = '0;
      slot_d   = '0;
      retire_d = '0;
      wait_d   = '0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARMED;
      cycle_q  <= '0;
      slot_q   <= '0;
      retire_q <= '0;
      wait_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      slot_q   <= slot_d;
      retire_q <= retire_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
    end
  end

  assign armed        = state_q[0];
  assign matched      = state_q[1];
  assign timeout      = state_q[2];
  assign stall_err    = err_q;
  assign match_slot   = slot_q;
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_rvfi_progress_monitor.sv
// Scoreboard bench for rvfi_progress_monitor (NRET=2, MAX_CYCLES=21, MAX_WAIT=1, CNT_W=8).
`timescale 1ns/1ps
module tb_rvfi_progress_monitor;

  localparam int unsigned NRET       = 2;
  localparam int unsigned ILEN       = 32;
  localparam int unsigned MAX_CYCLES = 21;
  localparam int unsigned MAX_WAIT   = 1;
  localparam int unsigned CNT_W      = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [31:0] match_insn;
  logic [1:0]  rvfi_valid;
  logic [63:0] rvfi_insn;
  logic        mem_valid;
  logic        mem_ready;
  logic        armed;
  logic        matched;
  logic        timeout;
  logic        stall_err;
  logic        match_slot;
  logic [7:0]  cycle_count;
  logic [7:0]  retire_count;

  rvfi_progress_monitor #(
    .NRET      (NRET),
    .ILEN      (ILEN),
    .MAX_CYCLES(MAX_CYCLES),
    .MAX_WAIT  (MAX_WAIT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .match_insn  (match_insn),
    .rvfi_valid  (rvfi_valid),
    .rvfi_insn   (rvfi_insn),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .armed       (armed),
    .matched     (matched),
    .timeout     (timeout),
    .stall_err   (stall_err),
    .match_slot  (match_slot),
    .cycle_count (cycle_count),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       armed;
    logic       matched;
    logic       timeout;
    logic       stall_err;
    logic       slot;
    logic [7:0] cyc;
    logic [7:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: 0 armed, 1 matched, 2 timed out.
  int m_state, m_cycle, m_retire, m_wait, m_slot;
  bit m_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_hit(input logic [31:0] m, input logic [31:0] i);
    if (m[1:0] == 2'b11) return m == i;
    return m[15:0] == i[15:0];
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_cycle  = 0;
    m_retire = 0;
    m_wait   = 0;
    m_slot   = 0;
    m_err    = 1'b0;
  endtask

  // Drive one cycle, push the model's prediction, then pop and compare after the edge.
  task automatic step(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                      input logic mv, input logic mr, input logic clr);
    exp_t e;
    bit   h0, h1;
    rvfi_valid = v;
    rvfi_insn  = {i1, i0};
    mem_valid  = mv;
    mem_ready  = mr;
    clear      = clr;
    if (clr) begin
      model_reset();
    end else begin
      h0 = v[0] && ref_hit(match_insn, i0);
      h1 = v[1] && ref_hit(match_insn, i1);
      m_retire = m_retire + int'(v[0]) + int'(v[1]);
      if (m_retire > 255) m_retire = 255;
      if (mv && !mr) begin
        if (m_wait == MAX_WAIT) m_err = 1'b1;
        if (m_wait < MAX_WAIT) m_wait++;
      end else begin
        m_wait = 0;
      end
      if (m_state == 0) begin
        if (h0) begin
          m_state = 1;
          m_slot  = 0;
        end else if (h1) begin
          m_state = 1;
          m_slot  = 1;
        end else if (m_cycle == MAX_CYCLES - 1) begin
          m_state = 2;
        end else begin
          m_cycle++;
        end
      end
    end
    e.armed     = (m_state == 0);
    e.matched   = (m_state == 1);
    e.timeout   = (m_state == 2);
    e.stall_err = m_err;
    e.slot      = m_slot[0];
    e.cyc       = m_cycle[7:0];
    e.ret       = m_retire[7:0];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("armed", armed, e.armed);
    check_eq("matched", matched, e.matched);
    check_eq("timeout", timeout, e.timeout);
    check_eq("stall_err", stall_err, e.stall_err);
    check_eq("match_slot", match_slot, e.slot);
    check_eq("cycle_count", cycle_count, e.cyc);
    check_eq("retire_count", retire_count, e.ret);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_armed"}, armed, 1'b1);
    check_eq({tag, "_matched"}, matched, 1'b0);
    check_eq({tag, "_timeout"}, timeout, 1'b0);
    check_eq({tag, "_stall_err"}, stall_err, 1'b0);
    check_eq({tag, "_slot"}, match_slot, 1'b0);
    check_eq({tag, "_cycle"}, cycle_count, 8'd0);
    check_eq({tag, "_retire"}, retire_count, 8'd0);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    clear      = 1'b0;
    rvfi_valid = 2'b00;
    rvfi_insn  = '0;
    mem_valid  = 1'b0;
    mem_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    match_insn = 32'h0000_0013;
    do_reset();
    check_reset_values("reset");

    // Match retires in cycle 5.
    idle(5);
    step(2'b01, 32'h0000_0013, 32'h0, 1'b0, 1'b1, 1'b0);
    check_eq("s1_matched", matched, 1'b1);
    check_eq("s1_cycle", cycle_count, 8'd5);
    check_eq("s1_timeout", timeout, 1'b0);

    // No match: timeout on the 21st cycle with cycle_count frozen at 20.
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    idle(20);
    check_eq("s2_still_armed", armed, 1'b1);
    idle(1);
    check_eq("s2_timeout", timeout, 1'b1);
    check_eq("s2_cycle", cycle_count, 8'd20);
    idle(3);
    check_eq("s2_sticky", timeout, 1'b1);

    // Hit in the bound cycle beats timeout.
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    idle(20);
    step(2'b01, 32'h0000_0013, 32'h0, 1'b0, 1'b1, 1'b0);
    check_eq("s3_matched", matched, 1'b1);
    check_eq("s3_cycle", cycle_count, 8'd20);

    // Compressed target compares only the low halfword.
    match_insn = 32'hABCD_4501;
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(2'b01, 32'hFFFF_4501, 32'h0, 1'b0, 1'b1, 1'b0);
    check_eq("s4_c_match", matched, 1'b1);

    // Full-width target: one differing bit must not match.
    match_insn = 32'h00A0_0513;
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(2'b01, 32'h00A0_0514, 32'h0, 1'b0, 1'b1, 1'b0);
    check_eq("s4_full_nomatch", armed, 1'b1);
    step(2'b01, 32'h10A0_0513, 32'h0, 1'b0, 1'b1, 1'b0);
    check_eq("s4_hi_nomatch", armed, 1'b1);
    step(2'b01, 32'h00A0_0513, 32'h0, 1'b0, 1'b1, 1'b0);
    check_eq("s4_full_match", matched, 1'b1);

    // Two channels hitting together: lowest slot reported, both retirements counted.
    match_insn = 32'h0000_0013;
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(2'b11, 32'h0000_0013, 32'h0000_0013, 1'b0, 1'b1, 1'b0);
    check_eq("s5_both_slot", match_slot, 1'b0);
    check_eq("s5_both_retire", retire_count, 8'd2);
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(2'b11, 32'h0000_0093, 32'h0000_0013, 1'b0, 1'b1, 1'b0);
    check_eq("s5_ch1_slot", match_slot, 1'b1);
    check_eq("s5_ch1_retire", retire_count, 8'd2);
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(2'b10, 32'h0, 32'h0000_0013, 1'b0, 1'b1, 1'b0);
    check_eq("s5_ch1_only", match_slot, 1'b1);

    // Handshake stalls: one wait cycle is tolerated, the second sets the sticky error.
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_eq("s6_one_stall", stall_err, 1'b0);
    step(2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_eq("s6_stall_reset_run", stall_err, 1'b0);
    step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_eq("s6_two_stall", stall_err, 1'b1);
    idle(2);
    check_eq("s6_sticky", stall_err, 1'b1);

    // Clear in TIMEOUT beats a simultaneous hit and stall.
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    idle(21);
    step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_eq("s7_pre_timeout", timeout, 1'b1);
    check_eq("s7_pre_err", stall_err, 1'b1);
    step(2'b01, 32'h0000_0013, 32'h0, 1'b1, 1'b0, 1'b1);
    check_reset_values("s7_clear");

    // Retire counter saturates instead of wrapping.
    for (int i = 0; i < 130; i++) step(2'b11, 32'h0, 32'h1, 1'b0, 1'b1, 1'b0);
    check_eq("s8_saturate", retire_count, 8'hFF);

    // Random traffic against the model, with occasional re-arm.
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 120; i++) begin
      logic [31:0] r0, r1;
      r0 = ($urandom_range(0, 7) == 0) ? match_insn : $urandom;
      r1 = ($urandom_range(0, 7) == 0) ? match_insn : $urandom;
      step(2'($urandom_range(0, 3)), r0, r1, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset mid-count, with hits ignored while it is held.
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    idle(7);
    step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("s9_async");
    rvfi_valid = 2'b11;
    rvfi_insn  = {32'h0000_0013, 32'h0000_0013};
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("s9_held");
    @(negedge clk);
    exp_q.delete();
    model_reset();
    reset = 1'b0;
    idle(3);
    check_eq("s9_post_cycle", cycle_count, 8'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvfi_progress_monitor.md
# rvfi_progress_monitor

Synthesizable progress/liveness monitor for minrv32 formal and simulation benches. It watches the RVFI retirement stream on `NRET` channels for a target instruction word and flags a timeout if the word does not retire within a cycle bound. It also checks the memory handshake for over-long wait runs. It is the parametrised, reusable generalisation of the per-bench "honest" checks: channel count, bound, stall limit and counter widths are configurable, and it adds retire counting, match-slot reporting and a synchronous re-arm.

## Interface
Parameters:
- `NRET`, 1: number of RVFI retirement channels.
- `ILEN`, 32: instruction width per channel.
- `MAX_CYCLES`, 21: cycles after arming within which the match must retire (≥1).
- `MAX_WAIT`, 1: max consecutive `mem_valid && !mem_ready` cycles tolerated (≥1).
- `CNT_W`, 8: width of cycle and retire counters; must hold `MAX_CYCLES`.

Ports:
- `clk` in 1: clock; everything is on the rising edge.
- `reset` in 1: **asynchronous, active-high** reset.
- `clear` in 1: synchronous re-arm; returns the monitor to ARMED and zeroes all counters.
- `match_insn` in ILEN: target instruction word; must be held stable while ARMED.
- `rvfi_valid` in NRET: per-channel retire strobe.
- `rvfi_insn` in NRET*ILEN: channel k occupies bits [k*ILEN +: ILEN].
- `mem_valid`, `mem_ready` in 1 each: core memory handshake.
- `armed`, `matched`, `timeout` out 1 each: one-hot state view.
- `stall_err` out 1: sticky flag, set on a handshake wait violation.
- `match_slot` out max(1,$clog2(NRET)): channel index that produced the match.
- `cycle_count` out CNT_W: number of cycles spent in ARMED.
- `retire_count` out CNT_W: saturating total of retirements since arm.

## Operation
- State machine: ARMED, MATCHED, TIMEOUT. ARMED is entered on reset or `clear`. MATCHED and TIMEOUT are sticky and left only via reset or `clear`.
- Per-channel hit: `rvfi_valid[k]` is set and the insn matches `match_insn`.
  - If `match_insn[1:0]==2'b11`, compare all ILEN bits.
  - Otherwise (compressed), compare bits [15:0] only.
- In ARMED:
  - If any channel hits: next state MATCHED, and `match_slot` ← lowest hitting index.
  - Else if `cycle_count == MAX_CYCLES-1`: next state TIMEOUT.
  - Otherwise `cycle_count` increments.
- A hit in the bound cycle wins over timeout. The match window is therefore cycles 0..MAX_CYCLES-1 after arming.
- In MATCHED and TIMEOUT, `cycle_count` holds its value.
- `retire_count`: adds popcount(`rvfi_valid`) each cycle in every state and saturates at 2^CNT_W-1 with no wrap.
- Stall check (active in every state):
  - `wait_cnt` increments while `mem_valid && !mem_ready` and clears otherwise.
  - `stall_err` sets when a stall cycle occurs with `wait_cnt == MAX_WAIT`, i.e. the (MAX_WAIT+1)-th consecutive stall cycle.
  - `wait_cnt` saturates at MAX_WAIT.
- `clear` has priority over a same-cycle hit, timeout and stall. It also clears `stall_err` and `wait_cnt`.

## Timing
- Reset values:
  - `armed`=1, `matched`=0, `timeout`=0, `stall_err`=0.
  - `match_slot`=0, `cycle_count`=0, `retire_count`=0, `wait_cnt`=0.
- All outputs are registered. A hit in cycle t shows as `matched`=1 in t+1, and `timeout` behaves the same way.
- Reset asserted mid-operation forces reset values immediately, asynchronously. Release takes effect on the next edge.
- Hits presented while `reset` is high are ignored.
- Multi-hit in one cycle: the lowest index is reported, and all valid bits are counted.

## Structure
- Package `rvfi_mon_pkg` holds:
  - the `mon_state_e` enum (ARMED, MATCHED, TIMEOUT);
  - the function `insn_hit(match, insn)` implementing the compressed-aware compare;
  - the `ILEN_DEFAULT` constant.
- One sub-module, `rvfi_insn_matcher`, is instantiated NRET times. It is combinational and produces `hit[k]`.
- The top level holds the FSM, counters, priority encoder and popcount.

## Test plan
- NRET=1, `match_insn`=32'h00000013. Retire it in cycle 5 → `matched`=1 in cycle 6, `cycle_count`=5, `timeout`=0.
- Same setup, never retire the match → `timeout`=1 in cycle 21 (MAX_CYCLES=21), `cycle_count`=20. A hit at cycle 20 instead gives `matched`.
- Compressed `match_insn`=32'hXXXX4501. Retire insn 32'hFFFF4501 → match. A full-width target 32'h00A00513 vs 32'h00A00514 → no match.
- NRET=2. Both channels hit in the same cycle → `match_slot`=0, `retire_count` +2. Channel 1 alone → `match_slot`=1.
- MAX_WAIT=1: one stall cycle → `stall_err`=0. Two consecutive stall cycles → `stall_err`=1 on the following edge.
- Assert `clear` in TIMEOUT together with a hit → ARMED, all counters 0, `stall_err`=0. Reset mid-count → immediate reset values.
